// File: rtl/fifo_burst_pkg.sv
// Shared types and elaboration helpers for the FIFO burst reader.
package fifo_burst_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  function automatic int cnt_width(input int burst);
    return $clog2(burst + 1);
  endfunction

  function automatic bit burst_ok(input int burst, input int asize);
    return (burst >= 1) && (burst <= (1 << asize));
  endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_buf2.sv
// Two-entry data+tag buffer; a write and a pop may occur in the same cycle at any occupancy.
module stream_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         wr_tag,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_tag,
  output logic [1:0]   occ
);

  logic [W-1:0] data_q [2];
  logic [W-1:0] data_d [2];
  logic [1:0]   tag_q, tag_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         do_pop;

  assign do_pop = pop && (occ_q != 2'd0);

  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + {1'b0, wr_en} - {1'b0, do_pop};
    if (wr_en) begin
      data_d[wr_ptr_q] = wr_data;
      tag_d[wr_ptr_q]  = wr_tag;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      data_q    <= data_d;
      tag_q     <= tag_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  assign head_data = data_q[rd_ptr_q];
  assign head_tag  = tag_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pulls fixed-size (or flushed partial) bursts from a standard-mode FIFO onto a valid/ready stream.
// Stream handshake: a word transfers on any cycle with m_valid && m_ready; m_data/m_last hold while stalled.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  input  logic [ASIZE:0]   fifo_rd_count,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy
);

  localparam int CW  = cnt_width(BURST);
  localparam int RCW = ASIZE + 1;
  localparam int XW  = (CW > RCW) ? CW : RCW;

  if (!burst_ok(BURST, ASIZE)) begin : g_bad_burst
    $error("fifo_burst_reader: BURST must be in 1..2**ASIZE");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic            inflight_q, inflight_d;
  logic            tag_pend_q, tag_pend_d;

  logic [CW-1:0]   cur_len, cur_issued;
  logic            start, active, is_last_issue, credit_ok, pop;
  logic [XW-1:0]   count_x, burst_x;
  logic [2:0]      credit_sum;
  logic [1:0]      occ;
  logic            head_tag;

  assign count_x    = XW'(fifo_rd_count);
  assign burst_x    = XW'(BURST);
  assign pop        = m_valid && m_ready;
  assign credit_sum = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok  = (credit_sum <= 3'd1);

  // A burst is started and its first read issued in the same IDLE cycle, so
  // back-to-back bursts cost only the one cycle spent waiting for inflight to clear.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issued_d      = issued_q;
    start         = 1'b0;
    cur_len       = len_q;
    cur_issued    = issued_q;
    active        = (state_q == ST_READ);
    if ((state_q == ST_IDLE) && !inflight_q) begin
      if (count_x >= burst_x) begin
        start   = 1'b1;
        cur_len = CW'(BURST);
      end else if (flush && !fifo_empty) begin
        start   = 1'b1;
        cur_len = CW'(fifo_rd_count);
      end
    end
    if (start) begin
      active     = 1'b1;
      cur_issued = '0;
      len_d      = cur_len;
      issued_d   = '0;
      state_d    = ST_READ;
    end
    is_last_issue = (cur_issued == (cur_len - CW'(1)));
    fifo_rd_en    = active && (cur_issued < cur_len) && !fifo_empty && credit_ok;
    if (fifo_rd_en) begin
      issued_d = cur_issued + CW'(1);
      if (is_last_issue) begin
        state_d = ST_IDLE;
      end
    end
    inflight_d = fifo_rd_en;
    tag_pend_d = fifo_rd_en && is_last_issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      tag_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      tag_pend_q <= tag_pend_d;
    end
  end

  stream_buf2 #(.W(DSIZE)) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en     (inflight_q),
    .wr_data   (fifo_dout),
    .wr_tag    (tag_pend_q),
    .pop       (pop),
    .head_data (m_data),
    .head_tag  (head_tag),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_last  = head_tag && m_valid;
  assign busy    = (state_q == ST_READ) || inflight_q || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed-vector and random bench for fifo_burst_reader with a behavioural standard-mode FIFO.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic [4:0] fifo_rd_count;
  logic       fifo_rd_en;
  logic       flush = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, m_last;
  logic       m_ready = 1'b1;
  logic       busy;

  fifo_burst_reader #(.DSIZE(8), .ASIZE(4), .BURST(4)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural FIFO (standard mode, depth 16) ----------------
  logic [7:0] fmem [16];
  int         fw, fr, fcnt;
  int         wr_cnt = 0;
  logic [7:0] wr_base = 8'h00;
  logic       rd_s;

  always @(negedge clk) rd_s = fifo_rd_en;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fw <= 0; fr <= 0; fcnt <= 0; fifo_dout <= 8'h00;
    end else begin
      for (int i = 0; i < wr_cnt; i++) fmem[(fw + i) % 16] <= wr_base + 8'(i);
      fw <= (fw + wr_cnt) % 16;
      if (rd_s && fcnt > 0) begin
        fifo_dout <= fmem[fr];
        fr <= (fr + 1) % 16;
      end
      fcnt <= fcnt + wr_cnt - ((rd_s && fcnt > 0) ? 1 : 0);
    end
  end

  assign fifo_rd_count = 5'(fcnt);
  assign fifo_empty    = (fcnt == 0);

  // ---------------- sink ready driver ----------------
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  int         n_pop = 0;
  int         seg_len = 0;
  bit         chk_last_en = 1'b1;
  bit         last_was_last = 1'b0;
  bit         hold_q = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(negedge clk) begin
    if (rst) begin
      if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 1'b0);
      if (hold_q) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, hold_data);
        chk("hold_last", m_last, hold_last);
      end
      if (m_valid && m_ready) begin
        n_pop++;
        seg_len++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          exp_e = exp_q.pop_front();
          chk("data", m_data, exp_e[7:0]);
          if (chk_last_en) chk("last", m_last, exp_e[8]);
        end
        if (m_last) begin
          chk("seg_len_le_burst", (seg_len <= 4), 1'b1);
          seg_len = 0;
        end
        last_was_last = m_last;
      end
      hold_q    = m_valid && !m_ready;
      hold_data = m_data;
      hold_last = m_last;
    end else begin
      hold_q  = 1'b0;
      seg_len = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int n, input logic [7:0] base, input logic [15:0] mask);
    wr_cnt  = n;
    wr_base = base;
    for (int i = 0; i < n; i++) exp_q.push_back({mask[i], base + 8'(i)});
    step();
    wr_cnt = 0;
  endtask

  task automatic drain(input string name, input int limit);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
    step();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_m_last"}, m_last, 1'b0);
    chk({tag, "_m_data"}, m_data, 8'h00);
    chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    int          nwords;
    logic [7:0]  base;
    bit          use_flush;
    int          rmode;
    logic [15:0] last_mask;
    logic [15:0] exp_pat;
    bit          chk_pat;
  } vec_t;

  vec_t       vecs [6];
  logic [15:0] pat;
  int          qcnt, t, base_pop;
  logic [7:0]  seq;
  int          wr;

  initial begin
    vecs[0] = '{4, 8'h10, 1'b0, 0, 16'h0008, 16'h000F, 1'b1};
    vecs[1] = '{3, 8'h20, 1'b1, 0, 16'h0004, 16'h0007, 1'b1};
    vecs[2] = '{4, 8'h28, 1'b0, 1, 16'h0008, 16'h0000, 1'b0};
    vecs[3] = '{8, 8'h30, 1'b0, 0, 16'h0088, 16'h01EF, 1'b1};
    vecs[4] = '{1, 8'h40, 1'b1, 0, 16'h0001, 16'h0001, 1'b1};
    vecs[5] = '{5, 8'h48, 1'b1, 0, 16'h0018, 16'h0001, 1'b1};

    // reset state
    #2;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      rmode = vecs[v].rmode;
      load(vecs[v].nwords, vecs[v].base, vecs[v].last_mask);
      if (vecs[v].use_flush) begin
        qcnt = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (fifo_rd_en) qcnt++;
          step();
        end
        if (vecs[v].nwords < 4) begin
          chk("quiet_rd_en", qcnt, 0);
          @(negedge clk);
          chk("quiet_busy", busy, 1'b0);
          step();
        end
        flush = 1'b1;
      end
      pat = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        pat[i] = fifo_rd_en;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      if (vecs[v].chk_pat) chk("rd_en_pattern", pat, vecs[v].exp_pat);
      drain("vec_drain", 200);
      @(negedge clk);
      chk("vec_idle_busy", busy, 1'b0);
      step();
    end

    // reset mid-burst after the second output word
    rmode = 0;
    base_pop = n_pop;
    load(4, 8'h60, 16'h0008);
    t = 0;
    while (n_pop < base_pop + 2 && t < 50) begin
      @(negedge clk); t++;
    end
    chk("reset_wait_two_words", (n_pop >= base_pop + 2), 1'b1);
    #1 rst = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    step();
    load(4, 8'h70, 16'h0008);
    drain("post_reset_drain", 100);
    @(negedge clk);
    chk("post_reset_busy", busy, 1'b0);
    step();

    // random traffic
    rmode = 2;
    chk_last_en = 1'b0;
    seq = 8'h80;
    for (int c = 0; c < 10000; c++) begin
      wr = (fcnt < 14 && $urandom_range(0, 3) != 0) ? 1 : 0;
      wr_cnt  = wr;
      wr_base = seq;
      if (wr == 1) begin
        exp_q.push_back({1'b0, seq});
        seq = seq + 8'd1;
      end
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    wr_cnt = 0;
    flush  = 1'b1;
    rmode  = 0;
    drain("rand_drain", 500);
    flush = 1'b0;
    chk("rand_final_last", last_was_last, 1'b1);
    repeat (4) step();
    @(negedge clk);
    chk("rand_idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
